// File: rtl/hid_kbd_event_sched.sv
// Turns 8-byte HID boot-keyboard reports into press/release events queued in a show-ahead FIFO.
// Optional macro HID_KBD_ROLLOVER_FILTER_EN: drop ErrorRollOver (byte2 == 8'h01) reports while idle.
module hid_kbd_event_sched #(
    parameter int DEPTH        = 16,
    parameter int REPORT_BYTES = 8
) (
    input  logic                      clk,
    input  logic                      reset_ni,
    input  logic [8*REPORT_BYTES-1:0] usb_report_i,
    input  logic                      usb_report_valid_i,
    output logic [8:0]                event_o,
    output logic                      event_valid_o,
    input  logic                      event_rd_i,
    output logic                      busy_o,
    output logic                      report_drop_o,
    input  logic                      clear_drop_i
);
    localparam int RW = 8 * REPORT_BYTES;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MODS   = 3'd1,
        REL    = 3'd2,
        PRESS  = 3'd3,
        COMMIT = 3'd4
    } state_t;

    state_t          state, state_nx;
    logic [2:0]      slot, slot_nx;
    logic [RW-1:0]   new_rpt, prev_rpt;
    logic [8:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            full, empty, push, pop, need_push, stall;
    logic            start, rollover, drop_set;
    logic [8:0]      push_data;
    logic [2:0]      key_byte;
    logic [7:0]      rel_key, press_key;

    function automatic logic key_in(input logic [RW-1:0] rpt, input logic [7:0] k);
        logic hit;
        hit = 1'b0;
        for (int b = 2; b < REPORT_BYTES; b++) begin
            hit = hit | (rpt[8*b +: 8] == k);
        end
        return hit;
    endfunction

`ifdef HID_KBD_ROLLOVER_FILTER_EN
    assign rollover = (usb_report_i[23:16] == 8'h01);
`else
    assign rollover = 1'b0;
`endif

    assign start    = usb_report_valid_i && (state == IDLE) && !rollover;
    assign drop_set = usb_report_valid_i && (state != IDLE);
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign stall    = need_push && full;
    assign push     = need_push && !full;
    assign pop      = event_rd_i && !empty;
    assign event_valid_o = !empty;
    assign event_o  = empty ? 9'd0 : mem[rd_ptr];

    // Keycode slots 0..5 map onto report bytes 2..7.
    assign key_byte  = slot + 3'd2;
    assign rel_key   = prev_rpt[{key_byte, 3'b000} +: 8];
    assign press_key = new_rpt[{key_byte, 3'b000} +: 8];

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state    <= IDLE;
            slot     <= 3'd0;
            prev_rpt <= '0;
        end else begin
            state <= state_nx;
            slot  <= slot_nx;
            if (state == COMMIT) prev_rpt <= new_rpt;
        end
    end

    always_ff @(posedge clk) begin
        if (start) new_rpt <= usb_report_i;
    end

    always_comb begin
        state_nx = state;
        slot_nx  = slot;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = MODS;
                    slot_nx  = 3'd0;
                end
            end
            MODS: begin
                if (!stall) begin
                    if (slot == 3'd7) begin
                        state_nx = REL;
                        slot_nx  = 3'd0;
                    end else begin
                        slot_nx = slot + 3'd1;
                    end
                end
            end
            REL: begin
                if (!stall) begin
                    if (slot == 3'd5) begin
                        state_nx = PRESS;
                        slot_nx  = 3'd0;
                    end else begin
                        slot_nx = slot + 3'd1;
                    end
                end
            end
            PRESS: begin
                if (!stall) begin
                    if (slot == 3'd5) begin
                        state_nx = COMMIT;
                        slot_nx  = 3'd0;
                    end else begin
                        slot_nx = slot + 3'd1;
                    end
                end
            end
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        need_push = 1'b0;
        push_data = 9'd0;
        busy_o    = 1'b0;
        case (state)
            MODS: begin
                busy_o = 1'b1;
                if (new_rpt[slot] != prev_rpt[slot]) begin
                    need_push = 1'b1;
                    push_data = {new_rpt[slot], 8'hE0 + {5'd0, slot}};
                end
            end
            REL: begin
                busy_o = 1'b1;
                if (rel_key != 8'h00 && !key_in(new_rpt, rel_key)) begin
                    need_push = 1'b1;
                    push_data = {1'b0, rel_key};
                end
            end
            PRESS: begin
                busy_o = 1'b1;
                if (press_key != 8'h00 && !key_in(prev_rpt, press_key)) begin
                    need_push = 1'b1;
                    push_data = {1'b1, press_key};
                end
            end
            default: ;
        endcase
    end

    // Event FIFO: full is taken from the registered count, so a pop frees space only next cycle.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni)         report_drop_o <= 1'b0;
        else if (drop_set)     report_drop_o <= 1'b1;
        else if (clear_drop_i) report_drop_o <= 1'b0;
    end
endmodule

// File: tb/tb_hid_kbd_event_sched.sv
// Self-checking bench for hid_kbd_event_sched with a 2-entry FIFO and a report-level event model.
module tb_hid_kbd_event_sched;
    typedef logic [8:0] ev_q_t[$];

    logic        clk = 1'b0;
    logic        reset_ni;
    logic [63:0] usb_report;
    logic        usb_report_valid;
    logic [8:0]  event_w;
    logic        event_valid;
    logic        event_rd;
    logic        busy;
    logic        report_drop;
    logic        clear_drop;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [63:0] prev_m = '0;

    always #5 clk = ~clk;

    hid_kbd_event_sched #(.DEPTH(2), .REPORT_BYTES(8)) dut (
        .clk                (clk),
        .reset_ni           (reset_ni),
        .usb_report_i       (usb_report),
        .usb_report_valid_i (usb_report_valid),
        .event_o            (event_w),
        .event_valid_o      (event_valid),
        .event_rd_i         (event_rd),
        .busy_o             (busy),
        .report_drop_o      (report_drop),
        .clear_drop_i       (clear_drop)
    );

    // Expected event list for one report, straight from the modifier/keycode rules.
    function automatic ev_q_t model(input logic [63:0] p, input logic [63:0] n);
        ev_q_t q;
        logic [7:0] pk[6];
        logic [7:0] nk[6];
        bit found;
        q = {};
        for (int i = 0; i < 6; i++) begin
            pk[i] = p[8*(i+2) +: 8];
            nk[i] = n[8*(i+2) +: 8];
        end
        for (int i = 0; i < 8; i++)
            if (n[i] != p[i]) q.push_back({n[i], 8'hE0 + 8'(i)});
        for (int i = 0; i < 6; i++) begin
            found = 0;
            for (int j = 0; j < 6; j++) if (nk[j] == pk[i]) found = 1;
            if (pk[i] != 8'h00 && !found) q.push_back({1'b0, pk[i]});
        end
        for (int i = 0; i < 6; i++) begin
            found = 0;
            for (int j = 0; j < 6; j++) if (pk[j] == nk[i]) found = 1;
            if (nk[i] != 8'h00 && !found) q.push_back({1'b1, nk[i]});
        end
        return q;
    endfunction

    function automatic bit filtered(input logic [63:0] n);
`ifdef HID_KBD_ROLLOVER_FILTER_EN
        return n[23:16] == 8'h01;
`else
        return 1'b0;
`endif
    endfunction

    task automatic send(input logic [63:0] r);
        @(negedge clk);
        usb_report       = r;
        usb_report_valid = 1'b1;
        @(posedge clk);
        #1;
        usb_report_valid = 1'b0;
    endtask

    // Pops whenever the head is valid and the cycle index is a multiple of gap, until the block is quiet.
    task automatic collect(input int gap, output ev_q_t got, output int busy_cycles,
                           output int first_valid, output bit timed_out);
        int quiet;
        int k;
        quiet = 0; k = 0; got = {}; busy_cycles = 0; first_valid = -1; timed_out = 0;
        while (quiet < 2) begin
            if (k >= 400) begin
                timed_out = 1;
                break;
            end
            @(negedge clk);
            event_rd = 1'b0;
            if (busy) busy_cycles++;
            if (event_valid && first_valid < 0) first_valid = k;
            if (event_valid && (k % gap == 0)) begin
                got.push_back(event_w);
                event_rd = 1'b1;
            end
            if (!busy && !event_valid) quiet++;
            else quiet = 0;
            k++;
        end
        event_rd = 1'b0;
    endtask

    task automatic test_reset;
        reset_ni = 1'b0; usb_report = '0; usb_report_valid = 0; event_rd = 0; clear_drop = 0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({event_w, event_valid, busy, report_drop} !== 12'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 000", {event_w, event_valid, busy, report_drop});
        end
        reset_ni = 1'b1;
        @(negedge clk);
        event_rd = 1'b1;
        @(negedge clk);
        event_rd = 1'b0;
        @(negedge clk);
        n_cmp++; if (event_valid !== 1'b0 || event_w !== 9'd0) begin
            n_fail++; $display("FAIL pop_empty: got valid=%b ev=%h expected valid=0 ev=000", event_valid, event_w);
        end
        prev_m = '0;
    endtask

    task automatic test_single_key;
        ev_q_t got; int bc, fv; bit to;
        send(64'h0000_0000_0004_0000);
        collect(1, got, bc, fv, to);
        n_cmp++; if (to) begin n_fail++; $display("FAIL single_timeout: got timeout expected completion"); end
        n_cmp++; if (bc != 20) begin n_fail++; $display("FAIL single_busy: got %0d cycles expected 20", bc); end
        n_cmp++; if (got.size() != 1) begin
            n_fail++; $display("FAIL single_count: got %0d expected 1", got.size());
        end else begin
            n_cmp++; if (got[0] !== 9'h104) begin n_fail++; $display("FAIL single_event: got %h expected 104", got[0]); end
        end
        send(64'h0);
        collect(1, got, bc, fv, to);
        n_cmp++; if (got.size() != 1) begin
            n_fail++; $display("FAIL release_count: got %0d expected 1", got.size());
        end else begin
            n_cmp++; if (got[0] !== 9'h004) begin n_fail++; $display("FAIL release_event: got %h expected 004", got[0]); end
        end
        prev_m = '0;
    endtask

    task automatic test_mods;
        ev_q_t got, exp; int bc, fv; bit to;
        exp = '{9'h1E1, 9'h1E5, 9'h107};
        send(64'h0000_0000_0007_0022);
        collect(2, got, bc, fv, to);
        n_cmp++; if (got.size() != exp.size()) begin
            n_fail++; $display("FAIL mods_count: got %0d expected %0d", got.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                n_cmp++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL mods_event%0d: got %h expected %h", i, got[i], exp[i]); end
            end
        end
        n_cmp++; if (fv != 2) begin n_fail++; $display("FAIL mods_first_valid: got cycle %0d expected 2", fv); end
        prev_m = 64'h0000_0000_0007_0022;
    endtask

    task automatic test_swap;
        ev_q_t got, exp; int bc, fv; bit to;
        send(64'h0000_0000_0504_0000);
        collect(1, got, bc, fv, to);
        exp = '{9'h004, 9'h106};
        send(64'h0000_0000_0605_0000);
        collect(1, got, bc, fv, to);
        n_cmp++; if (got.size() != exp.size()) begin
            n_fail++; $display("FAIL swap_count: got %0d expected %0d", got.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                n_cmp++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL swap_event%0d: got %h expected %h", i, got[i], exp[i]); end
            end
        end
        prev_m = 64'h0000_0000_0605_0000;
    endtask

    task automatic test_backpressure;
        ev_q_t got, exp; int bc, fv; bit to;
        send(64'h0);
        collect(1, got, bc, fv, to);
        exp = '{9'h104, 9'h105, 9'h106, 9'h107, 9'h108, 9'h109};
        send(64'h0908_0706_0504_0000);
        repeat (30) @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || event_valid !== 1'b1 || event_w !== 9'h104) begin
            n_fail++; $display("FAIL stall_state: got busy=%b valid=%b ev=%h expected 1 1 104", busy, event_valid, event_w);
        end
        usb_report = 64'h0000_0000_0011_0000; usb_report_valid = 1'b1;
        @(negedge clk);
        usb_report_valid = 1'b0;
        n_cmp++; if (report_drop !== 1'b1) begin n_fail++; $display("FAIL drop_set: got %b expected 1", report_drop); end
        clear_drop = 1'b1;
        @(negedge clk);
        clear_drop = 1'b0;
        n_cmp++; if (report_drop !== 1'b0) begin n_fail++; $display("FAIL drop_clear: got %b expected 0", report_drop); end
        usb_report_valid = 1'b1; clear_drop = 1'b1;
        @(negedge clk);
        usb_report_valid = 1'b0; clear_drop = 1'b0;
        n_cmp++; if (report_drop !== 1'b1) begin n_fail++; $display("FAIL drop_set_wins: got %b expected 1", report_drop); end
        clear_drop = 1'b1;
        @(negedge clk);
        clear_drop = 1'b0;
        collect(3, got, bc, fv, to);
        n_cmp++; if (to) begin n_fail++; $display("FAIL stall_timeout: got timeout expected completion"); end
        n_cmp++; if (got.size() != exp.size()) begin
            n_fail++; $display("FAIL stall_count: got %0d expected %0d", got.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                n_cmp++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL stall_event%0d: got %h expected %h", i, got[i], exp[i]); end
            end
        end
        prev_m = 64'h0908_0706_0504_0000;
    endtask

    task automatic test_rollover;
        ev_q_t got, exp; int bc, fv; bit to;
        logic [63:0] r;
        r = 64'h0000_0000_0001_0000;
        exp = filtered(r) ? '{} : model(prev_m, r);
        send(r);
        collect(1, got, bc, fv, to);
        n_cmp++; if (bc != (filtered(r) ? 0 : 20)) begin
            n_fail++; $display("FAIL rollover_busy: got %0d expected %0d", bc, filtered(r) ? 0 : 20);
        end
        n_cmp++; if (got.size() != exp.size()) begin
            n_fail++; $display("FAIL rollover_count: got %0d expected %0d", got.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                n_cmp++; if (got[i] !== exp[i]) begin n_fail++; $display("FAIL rollover_event%0d: got %h expected %h", i, got[i], exp[i]); end
            end
        end
        if (!filtered(r)) prev_m = r;
    endtask

    task automatic test_random;
        ev_q_t got, exp; int bc, fv, gap; bit to;
        logic [63:0] r;
        logic [7:0] pool[8];
        pool = '{8'h00, 8'h00, 8'h01, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        for (int it = 0; it < 25; it++) begin
            r[7:0]  = ($urandom_range(0, 1) == 1) ? prev_m[7:0] : 8'($urandom);
            r[15:8] = 8'($urandom);
            for (int b = 2; b < 8; b++) r[8*b +: 8] = pool[$urandom_range(0, 7)];
            if (it % 6 == 5) r = prev_m;
            gap = $urandom_range(1, 3);
            exp = filtered(r) ? '{} : model(prev_m, r);
            send(r);
            collect(gap, got, bc, fv, to);
            n_cmp++; if (to) begin n_fail++; $display("FAIL rand%0d_timeout: got timeout expected completion", it); end
            if (gap == 1) begin
                n_cmp++; if (bc != (filtered(r) ? 0 : 20)) begin
                    n_fail++; $display("FAIL rand%0d_busy: got %0d expected %0d", it, bc, filtered(r) ? 0 : 20);
                end
            end
            n_cmp++; if (got.size() != exp.size()) begin
                n_fail++; $display("FAIL rand%0d_count: got %0d expected %0d (report %h)", it, got.size(), exp.size(), r);
            end else begin
                for (int i = 0; i < exp.size(); i++) begin
                    n_cmp++; if (got[i] !== exp[i]) begin
                        n_fail++; $display("FAIL rand%0d_event%0d: got %h expected %h", it, i, got[i], exp[i]);
                    end
                end
            end
            if (!filtered(r)) prev_m = r;
        end
    endtask

    task automatic test_midscan_reset;
        ev_q_t got; int bc, fv; bit to;
        send(prev_m ^ 64'hFF);
        repeat (5) @(negedge clk);
        usb_report_valid = 1'b1;
        @(negedge clk);
        usb_report_valid = 1'b0;
        n_cmp++; if (event_valid !== 1'b1 || report_drop !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL midscan_pre: got valid=%b drop=%b busy=%b expected 1 1 1", event_valid, report_drop, busy);
        end
        reset_ni = 1'b0;
        #1;
        n_cmp++; if ({event_w, event_valid, busy, report_drop} !== 12'd0) begin
            n_fail++; $display("FAIL midscan_reset: got %h expected 000", {event_w, event_valid, busy, report_drop});
        end
        repeat (2) @(negedge clk);
        reset_ni = 1'b1;
        prev_m = '0;
        send(64'h0);
        collect(1, got, bc, fv, to);
        n_cmp++; if (got.size() != 0) begin n_fail++; $display("FAIL midscan_prev: got %0d events expected 0", got.size()); end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_mods();
        test_swap();
        test_backpressure();
        test_rollover();
        test_random();
        test_midscan_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end
endmodule
